// File: rtl/reg_bus_regfile.sv
// REG_BUS responder with a bank of byte-writable registers and one read wait state.
// Optional macro REG_BUS_REGFILE_STATUS_EN maps a read-only status_i word at address NUM_REGS.
module reg_bus_regfile #(
  parameter int                      ADDR_WIDTH  = 4,
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ADDR_WIDTH-1:0]          reg_addr_i,
  input  logic                           reg_write_i,
  input  logic [DATA_WIDTH-1:0]          reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        reg_wstrb_i,
  input  logic                           reg_valid_i,
  output logic [DATA_WIDTH-1:0]          reg_rdata_o,
  output logic                           reg_error_o,
  output logic                           reg_ready_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
`ifdef REG_BUS_REGFILE_STATUS_EN
  ,
  input  logic [DATA_WIDTH-1:0]          status_i
`endif
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   sel;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wmask;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] acc_rdata;

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel     = '0;
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (reg_addr_i == ADDR_WIDTH'(k)) begin
        sel[k]  = 1'b1;
        rd_word = regs_q[k];
      end
    end
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      wmask[8*b +: 8] = {8{reg_wstrb_i[b]}};
    end
  end

  // Decode result for the request being accepted; writes always return zero data.
  always_comb begin
`ifdef REG_BUS_REGFILE_STATUS_EN
    if (reg_addr_i == STATUS_ADDR) begin
      acc_err   = reg_write_i;
      acc_rdata = reg_write_i ? '0 : status_i;
    end else begin
      acc_err   = ~(|sel);
      acc_rdata = (reg_write_i || !(|sel)) ? '0 : rd_word;
    end
`else
    acc_err   = ~(|sel);
    acc_rdata = (reg_write_i || !(|sel)) ? '0 : rd_word;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      reg_ready_o <= 1'b0;
      reg_error_o <= 1'b0;
      reg_rdata_o <= '0;
      wr_pulse_o  <= '0;
      // NOTE: the register bank is software-visible state, so it is reset explicitly rather than left as uninitialised storage.
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VALUE;
      end
    end else begin
      wr_pulse_o <= '0;
      case (state_q)
        IDLE: begin
          if (reg_valid_i) begin
            state_q     <= ACCESS;
            reg_ready_o <= 1'b1;
            reg_error_o <= acc_err;
            reg_rdata_o <= acc_rdata;
          end
        end
        ACCESS: begin
          state_q     <= IDLE;
          reg_ready_o <= 1'b0;
          // A dropped valid here is a protocol violation and commits nothing.
          if (reg_valid_i && reg_write_i && !reg_error_o && (|reg_wstrb_i)) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (sel[k]) begin
                regs_q[k] <= (regs_q[k] & ~wmask) | (reg_wdata_i & wmask);
              end
            end
            wr_pulse_o <= sel;
          end
        end
        default: begin
          state_q     <= IDLE;
          reg_ready_o <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_reg_bus_regfile.sv
// Directed table-driven bench for reg_bus_regfile (default parameters).
// Status-word vectors are selected when REG_BUS_REGFILE_STATUS_EN is defined.
module tb_reg_bus_regfile;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int RW = NR * DW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          write;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          valid;
  logic [DW-1:0] rdata;
  logic          error;
  logic          ready;
  logic [RW-1:0] regs;
  logic [NR-1:0] pulse;
`ifdef REG_BUS_REGFILE_STATUS_EN
  logic [DW-1:0] status = 32'hA5A5_A5A5;
`endif

  reg_bus_regfile dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .reg_addr_i  (addr),
    .reg_write_i (write),
    .reg_wdata_i (wdata),
    .reg_wstrb_i (wstrb),
    .reg_valid_i (valid),
    .reg_rdata_o (rdata),
    .reg_error_o (error),
    .reg_ready_o (ready),
    .regs_o      (regs),
    .wr_pulse_o  (pulse)
`ifdef REG_BUS_REGFILE_STATUS_EN
    ,
    .status_i    (status)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic [NR-1:0] exp_pulse;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] model [NR];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                              input logic [3:0] s, input logic [DW-1:0] er, input logic ee,
                              input logic [NR-1:0] ep);
    vec_t v;
    v.addr = a; v.write = w; v.wdata = d; v.wstrb = s;
    v.exp_rdata = er; v.exp_err = ee; v.exp_pulse = ep;
    return v;
  endfunction

  function automatic logic [RW-1:0] model_flat();
    logic [RW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
    return f;
  endfunction

  // Reference byte-merge applied only for committed writes to real registers.
  task automatic model_write(input vec_t v);
    if (v.write && v.addr < NR && v.wstrb != 4'b0000) begin
      for (int b = 0; b < 4; b++) begin
        if (v.wstrb[b]) model[v.addr][8*b +: 8] = v.wdata[8*b +: 8];
      end
    end
  endtask

  // Called at posedge+1; leaves valid high so consecutive calls run back-to-back.
  task automatic xfer(input vec_t v, input string name);
    addr = v.addr; write = v.write; wdata = v.wdata; wstrb = v.wstrb; valid = 1'b1;
    @(posedge clk); #1;
    check({name, " ready"}, RW'(ready), RW'(1'b1));
    check({name, " rdata"}, RW'(rdata), RW'(v.exp_rdata));
    check({name, " error"}, RW'(error), RW'(v.exp_err));
    check({name, " pulse_early"}, RW'(pulse), '0);
    @(posedge clk); #1;
    model_write(v);
    check({name, " ready_gap"}, RW'(ready), RW'(1'b0));
    check({name, " pulse"}, RW'(pulse), RW'(v.exp_pulse));
    check({name, " regs"}, regs, model_flat());
  endtask

  initial begin
    for (int k = 0; k < NR; k++) model[k] = '0;
    for (int a = 0; a < NR; a++) vecs.push_back(mk(AW'(a), 1'b0, '0, 4'h0, '0, 1'b0, '0));
    vecs.push_back(mk(4'd3, 1'b1, 32'hDEAD_BEEF, 4'b1111, '0, 1'b0, 8'b0000_1000));
    vecs.push_back(mk(4'd3, 1'b0, '0, 4'h0, 32'hDEAD_BEEF, 1'b0, '0));
    vecs.push_back(mk(4'd3, 1'b1, 32'h1122_3344, 4'b0101, '0, 1'b0, 8'b0000_1000));
    vecs.push_back(mk(4'd3, 1'b0, '0, 4'h0, 32'hDE22_BE44, 1'b0, '0));
    vecs.push_back(mk(4'd3, 1'b1, 32'hFFFF_FFFF, 4'b0000, '0, 1'b0, '0));
    vecs.push_back(mk(4'd3, 1'b0, '0, 4'h0, 32'hDE22_BE44, 1'b0, '0));
    vecs.push_back(mk(4'd9, 1'b0, '0, 4'h0, '0, 1'b1, '0));
    vecs.push_back(mk(4'd9, 1'b1, 32'hCAFE_F00D, 4'b1111, '0, 1'b1, '0));
`ifdef REG_BUS_REGFILE_STATUS_EN
    vecs.push_back(mk(4'd8, 1'b0, '0, 4'h0, 32'hA5A5_A5A5, 1'b0, '0));
`else
    vecs.push_back(mk(4'd8, 1'b0, '0, 4'h0, '0, 1'b1, '0));
`endif
    vecs.push_back(mk(4'd8, 1'b1, 32'h1234_5678, 4'b1111, '0, 1'b1, '0));
    vecs.push_back(mk(4'd7, 1'b1, 32'h0000_00AA, 4'b0001, '0, 1'b0, 8'b1000_0000));
    vecs.push_back(mk(4'd7, 1'b0, '0, 4'h0, 32'h0000_00AA, 1'b0, '0));
    vecs.push_back(mk(4'd15, 1'b0, '0, 4'h0, '0, 1'b1, '0));
    vecs.push_back(mk(4'd0, 1'b1, 32'h0123_4567, 4'b1111, '0, 1'b0, 8'b0000_0001));
    vecs.push_back(mk(4'd1, 1'b1, 32'h89AB_CDEF, 4'b1111, '0, 1'b0, 8'b0000_0010));

    rst_n = 1'b0; addr = '0; write = 1'b0; wdata = '0; wstrb = '0; valid = 1'b0;
    #12;
    check("reset ready", RW'(ready), '0);
    check("reset error", RW'(error), '0);
    check("reset rdata", RW'(rdata), '0);
    check("reset pulse", RW'(pulse), '0);
    check("reset regs", regs, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) xfer(vecs[i], $sformatf("vec%0d", i));
    valid = 1'b0;
    @(posedge clk); #1;
    check("trailing pulse", RW'(pulse), '0);

    // Valid dropped during ACCESS: no commit and no pulse.
    addr = 4'd5; write = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111; valid = 1'b1;
    @(posedge clk); #1;
    check("drop ready", RW'(ready), RW'(1'b1));
    valid = 1'b0;
    @(posedge clk); #1;
    check("drop ready_low", RW'(ready), '0);
    check("drop pulse", RW'(pulse), '0);
    check("drop regs", regs, model_flat());
    @(posedge clk); #1;
    check("drop idle", RW'(ready), '0);

    // Reset asserted during ACCESS of a write.
    addr = 4'd2; write = 1'b1; wdata = 32'h5555_5555; wstrb = 4'b1111; valid = 1'b1;
    @(posedge clk); #1;
    check("rst ready_before", RW'(ready), RW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("rst ready_async", RW'(ready), '0);
    for (int k = 0; k < NR; k++) model[k] = '0;
    check("rst regs", regs, model_flat());
    valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst pulse", RW'(pulse), '0);
    check("rst reg2", RW'(regs[2*DW +: DW]), '0);
    @(posedge clk); #1;
    check("rst pulse_late", RW'(pulse), '0);
    check("rst ready_late", RW'(ready), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_regfile.md
# reg_bus_regfile

Register-bank responder for the REG_BUS protocol. It implements the `in` side of the bus: it accepts initiator requests, stores writes into a bank of software-visible registers, and returns read data with one wait state. Register contents are exported flat to the surrounding datapath, together with a one-cycle write-notification pulse per register.

## Interface
Parameters:
- ADDR_WIDTH, 4: width of the word address. `addr` is a word index, not a byte address.
- DATA_WIDTH, 32: register and bus data width. Must be a multiple of 8.
- NUM_REGS, 8: number of read/write registers. Requires 1 ≤ NUM_REGS < 2**ADDR_WIDTH.
- RESET_VALUE, '0: reset value of every register, DATA_WIDTH bits.

Ports:
- clk_i, input, 1: single clock; all logic is rising-edge.
- rst_ni, input, 1: asynchronous, active-low reset.
- reg_addr_i, input, ADDR_WIDTH: request word address.
- reg_write_i, input, 1: 1 = write, 0 = read.
- reg_wdata_i, input, DATA_WIDTH: write data.
- reg_wstrb_i, input, DATA_WIDTH/8: byte write strobes.
- reg_valid_i, input, 1: request valid.
- reg_rdata_o, output, DATA_WIDTH: read data; meaningful only while reg_ready_o=1.
- reg_error_o, output, 1: access error; meaningful only while reg_ready_o=1.
- reg_ready_o, output, 1: transfer completes in the cycle where reg_valid_i and reg_ready_o are both 1.
- regs_o, output, NUM_REGS*DATA_WIDTH: register contents. Register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o, output, NUM_REGS: one-hot pulse indicating that register k was written.
- status_i, input, DATA_WIDTH: present only with REG_BUS_REGFILE_STATUS_EN.

## Operation
- Two-state FSM.
  - IDLE: reg_ready_o=0. When reg_valid_i=1, the block captures the read data and error flag and moves to ACCESS.
  - ACCESS: reg_ready_o=1. If reg_valid_i=1, the handshake completes and the FSM returns to IDLE.
  - If reg_valid_i drops in ACCESS (a protocol violation), the FSM returns to IDLE with no write and no pulse.
- The initiator holds addr, write, wdata, wstrb and valid stable from assertion until the handshake.
- Address decode:
  - addr < NUM_REGS: valid register; error=0.
  - Any other address: error=1, rdata=0, no state change.
- Read: rdata = register[addr], captured at the IDLE→ACCESS edge.
- Write:
  - Commits at the handshake edge, i.e. the clock edge ending the ACCESS cycle.
  - For each byte b with wstrb[b]=1, reg[addr][8b+7:8b] takes wdata[8b+7:8b]. Other bytes are unchanged.
  - For writes, rdata=0.
- wstrb all-zero on a valid address: handshake completes, error=0, no register change, no pulse.
- wr_pulse_o[addr] is 1 for exactly the cycle after a committed write with a non-zero strobe to a valid address. All other bits are 0.
- regs_o reflects the new value in the same cycle that wr_pulse_o is high.

## Timing
- Reset values (asynchronous, immediate on rst_ni=0):
  - FSM = IDLE.
  - reg_ready_o=0, reg_error_o=0, reg_rdata_o=0.
  - Every register = RESET_VALUE.
  - wr_pulse_o=0.
- Latency: valid rises in cycle N; ready=1 in cycle N+1; handshake in cycle N+1.
- Throughput: back-to-back requests complete every 2 cycles, because ready is forced to 0 for at least one cycle between transfers.
- A read issued immediately after a write to the same register returns the written value.
- Reset during ACCESS: ready drops asynchronously and the pending write is discarded.
- reg_rdata_o and reg_error_o are registered outputs. No combinational path exists from any input to any output.

## Configuration
- Macro: REG_BUS_REGFILE_STATUS_EN.
- Defined:
  - Adds the status_i port.
  - Address NUM_REGS reads status_i, sampled at the IDLE→ACCESS edge, with error=0.
  - A write to address NUM_REGS returns error=1 and changes nothing.
  - Addresses above NUM_REGS return error=1.
- Undefined: status_i is absent, and address NUM_REGS returns error=1 like any other out-of-range address.

## Test plan
- Reset, then read each of addresses 0..7 → ready in the second cycle of each transfer, rdata=0, error=0; wr_pulse_o stays 0.
- Write addr 3, wdata 0xDEADBEEF, wstrb 4'b1111, then read addr 3 → rdata=0xDEADBEEF; wr_pulse_o=8'b0000_1000 for one cycle; regs_o[127:96]=0xDEADBEEF.
- Partial strobe: with reg 3=0xDEADBEEF, write 0x11223344 with wstrb 4'b0101 → reg 3=0xDE22BE44. With wstrb 4'b0000 → unchanged, error=0, no pulse.
- Access to address 9 (read and write) → error=1, rdata=0, all registers unchanged, no pulse. With STATUS_EN and status_i=0xA5A5A5A5: read addr 8 → rdata=0xA5A5A5A5, error=0; write addr 8 → error=1.
- Back-to-back writes to addr 0 and addr 1 with valid held high → each completes 2 cycles apart, with a ready gap of 1 cycle between them.
- Assert rst_ni=0 during ACCESS of a write to addr 2 → ready drops immediately; reg 2 = RESET_VALUE; no pulse after reset is released.
